part1_sweep_ctrl: RTL and testbench
===================================

PART1_SWEEP_CTRL -- requirements
Module: part1_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, cycles sw_out is held before led_in is sampled; legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request a full 32-code sweep; sampled in IDLE only.
REQ-005 SHALL have port abort  input  1  terminate a running sweep.
REQ-006 SHALL have port led_in  input  1  combinational result from the Part1 switch-to-LED datapath.
REQ-007 SHALL have port sw_out  output  5  switch code driven into the Part1 datapath.
REQ-008 SHALL have port busy  output  1  high in SETTLE and SAMPLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-010 SHALL have port ones_count  output  6  number of codes for which led_in was 1 (0..32).
REQ-011 SHALL have port truth_table  output  32  bit i = led_in sampled for code i.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-013 IDLE: start=1 at an edge -> SETTLE, code=0, settle counter=0, ones_count=0, truth_table=0.
REQ-014 SETTLE: sw_out=code; counter increments each cycle; after SETTLE_CYCLES cycles -> SAMPLE.
REQ-015 SAMPLE (1 cycle): at its closing edge truth_table[code]<=led_in, ones_count<=ones_count+led_in; code<31 -> code+1, SETTLE; code==31 -> DONE.
REQ-016 DONE: done=1 for exactly one cycle, busy=0, then IDLE; results hold until next accepted start.
REQ-017 Latency: done is high in cycle 32*(SETTLE_CYCLES+1)+1 counted from the start-accepting edge (cycle 1 = first SETTLE cycle).
REQ-018 sw_out=0 in IDLE and DONE; the code counter does not wrap past 31.
REQ-019 start while busy or in DONE is ignored and does not restart or extend the sweep.
REQ-020 abort in SETTLE or SAMPLE -> IDLE at next edge, no done pulse, partial results held; abort in the same cycle as a SAMPLE capture takes priority (no capture).
REQ-021 abort in IDLE or DONE has no effect; abort and start together in IDLE -> stay IDLE.
REQ-022 ones_count SHALL be 6 bits so that 32 fits without overflow.

Reset
REQ-023 rst_n low asynchronously forces IDLE, sw_out=0, busy=0, done=0, ones_count=0, truth_table=0, counters=0.
REQ-024 Reset mid-sweep discards all progress; no done pulse follows reset release.
REQ-025 After rst_n rises, first start is accepted no earlier than the first rising edge with rst_n high.

Structure
REQ-026 Shared package part1_sweep_pkg SHALL hold state encoding, CODE_W=5, NUM_CODES=32, COUNT_W=6.
REQ-027 Settle counter SHALL be a sub-module part1_settle_timer (load/expire, width 4); all else in one module.

Verification (bench uses behavioural Part1 model unless stated)
REQ-028 Model LED=^sw, SETTLE_CYCLES=2, start pulse -> done in cycle 97, ones_count=16, truth_table=0x96696996.
REQ-029 led_in tied 1 then tied 0 -> ones_count=32/truth_table=0xFFFFFFFF, then 0/0x00000000.
REQ-030 abort asserted while sw_out=10 in SAMPLE -> IDLE next cycle, no done, truth_table bits 10..31 = 0, busy=0.
REQ-031 start re-pulsed at cycles 5 and 96 of a sweep -> single done pulse at cycle 97, results unchanged.
REQ-032 rst_n low asynchronously mid-SETTLE (between edges) -> outputs zero immediately; new start -> full correct sweep.
REQ-033 SETTLE_CYCLES=1 and 15 -> done at cycles 65 and 513 respectively, parity results as REQ-028.

Source files
------------

// File: rtl/part1_sweep_pkg.sv
// Shared encoding and sizing for the Part1 switch-code sweep controller.
package part1_sweep_pkg;

    localparam int CODE_W    = 5;
    localparam int NUM_CODES = 32;
    localparam int COUNT_W   = 6;
    localparam int TIMER_W   = 4;

    localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NUM_CODES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/part1_settle_timer.sv
// Settle-time counter: restarts at zero on load, flags expire on the last settle cycle.
module part1_settle_timer
    import part1_sweep_pkg::*;
#(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

    logic [TIMER_W-1:0] count_reg;

    // Saturates at LAST so a stalled enable can never wrap the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= '0;
        end else if (en && (count_reg != LAST)) begin
            count_reg <= count_reg + TIMER_W'(1);
        end
    end

    assign expire = (count_reg == LAST);

endmodule

// File: rtl/part1_sweep_ctrl.sv
// Walks all 32 switch codes through the Part1 datapath and records the LED response.
module part1_sweep_ctrl
    import part1_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 led_in,
    output logic [CODE_W-1:0]    sw_out,
    output logic                 busy,
    output logic                 done,
    output logic [COUNT_W-1:0]   ones_count,
    output logic [NUM_CODES-1:0] truth_table
);

    state_t                 state_reg, state_next;
    logic [CODE_W-1:0]      code_reg, code_next;
    logic [COUNT_W-1:0]     ones_reg, ones_next;
    logic [NUM_CODES-1:0]   table_reg, table_next;
    logic [CODE_W-1:0]      sw_reg, sw_next;
    logic                   busy_reg, busy_next;
    logic                   done_reg, done_next;
    logic                   timer_load;
    logic                   timer_en;
    logic                   timer_expire;

    part1_settle_timer #(
        .LIMIT (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (timer_load),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            code_reg  <= '0;
            ones_reg  <= '0;
            table_reg <= '0;
            sw_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            ones_reg  <= ones_next;
            table_reg <= table_next;
            sw_reg    <= sw_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        ones_next  = ones_reg;
        table_next = table_reg;
        timer_load = 1'b0;
        timer_en   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_next = ST_SETTLE;
                    code_next  = '0;
                    ones_next  = '0;
                    table_next = '0;
                    timer_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (timer_expire) begin
                    state_next = ST_SAMPLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                // Abort wins over the capture so a cancelled code leaves no trace.
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    table_next[code_reg] = led_in;
                    ones_next            = ones_reg + COUNT_W'(led_in);
                    if (code_reg == LAST_CODE) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SETTLE;
                        code_next  = code_reg + CODE_W'(1);
                        timer_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies.
        busy_next = (state_next == ST_SETTLE) || (state_next == ST_SAMPLE);
        done_next = (state_next == ST_DONE);
        sw_next   = busy_next ? code_next : '0;
    end

    assign sw_out      = sw_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign ones_count  = ones_reg;
    assign truth_table = table_reg;

endmodule

// File: tb/tb_part1_sweep_ctrl.sv
// Randomized bench for three sweep controllers (SETTLE_CYCLES 1, 2, 15) against a cycle-count model.
module tb_part1_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_v   [3];
    logic        abort_v   [3];
    logic        led_v     [3];
    logic        busy_v    [3];
    logic        done_v    [3];
    logic        led_par   [3];
    logic [4:0]  sw_v      [3];
    logic [5:0]  ones_v    [3];
    logic [31:0] tt_v      [3];
    logic [31:0] led_tbl   [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic int sc_of(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 2 : 15;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int SC = (gi == 0) ? 1 : (gi == 1) ? 2 : 15;

            // Behavioural Part1 datapath: parity of the switches, or an arbitrary table.
            assign led_v[gi] = led_par[gi] ? ^sw_v[gi] : led_tbl[gi][sw_v[gi]];

            part1_sweep_ctrl #(
                .SETTLE_CYCLES (SC)
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .start       (start_v[gi]),
                .abort       (abort_v[gi]),
                .led_in      (led_v[gi]),
                .sw_out      (sw_v[gi]),
                .busy        (busy_v[gi]),
                .done        (done_v[gi]),
                .ones_count  (ones_v[gi]),
                .truth_table (tt_v[gi])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected LED for code j from the current datapath model.
    function automatic logic model_led(input int idx, input int j);
        logic [4:0] jj;
        logic [31:0] tbl;
        jj  = j[4:0];
        tbl = led_tbl[idx];
        return led_par[idx] ? ^jj : tbl[j];
    endfunction

    // start_mode: 0 none, 1 re-pulse at cycles 5 and 96, 2 random pulses while not idle.
    task automatic run_sweep(input int idx, input int abort_at, input int start_mode, input string name);
        int          s, p, total, eff_abort;
        int          done_cnt, done_cyc, bad_sw, bad_busy;
        int          exp_sw;
        logic        exp_busy, live;
        logic [31:0] exp_tt;

        s         = sc_of(idx);
        p         = s + 1;
        total     = 32 * p + 1;
        eff_abort = (abort_at > 0 && abort_at <= 32 * p) ? abort_at : 0;
        done_cnt  = 0;
        done_cyc  = 0;
        bad_sw    = 0;
        bad_busy  = 0;

        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;

        for (int c = 1; c <= total + 3; c++) begin
            exp_busy = (eff_abort == 0 || c <= eff_abort) && (c <= 32 * p);
            exp_sw   = exp_busy ? (c - 1) / p : 0;
            if (busy_v[idx] !== exp_busy) bad_busy++;
            if (sw_v[idx] !== 5'(exp_sw)) bad_sw++;
            if (done_v[idx] === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            abort_v[idx] = (c == abort_at);
            live = (c <= total) && (eff_abort == 0 || c < eff_abort);
            case (start_mode)
                1:       start_v[idx] = live && (c == 5 || c == 96);
                2:       start_v[idx] = live && ($urandom_range(0, 7) == 0);
                default: start_v[idx] = 1'b0;
            endcase
            @(posedge clk);
            #1;
        end
        abort_v[idx] = 1'b0;
        start_v[idx] = 1'b0;

        exp_tt = '0;
        for (int j = 0; j < 32; j++) begin
            if (eff_abort == 0 || (j + 1) * p < eff_abort) exp_tt[j] = model_led(idx, j);
        end

        check({name, ".done_count"}, done_cnt, (eff_abort == 0) ? 1 : 0);
        check({name, ".done_cycle"}, done_cyc, (eff_abort == 0) ? total : 0);
        check({name, ".ones_count"}, ones_v[idx], $countones(exp_tt));
        check({name, ".truth_table"}, tt_v[idx], exp_tt);
        check({name, ".busy_trace"}, bad_busy, 0);
        check({name, ".sw_trace"}, bad_sw, 0);
        $display("sweep %s: settle=%0d abort_at=%0d done_cycle=%0d ones=%0d table=%08h",
                 name, s, abort_at, done_cyc, ones_v[idx], tt_v[idx]);
    endtask

    initial begin
        int idx, ab, done_seen;

        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            abort_v[i] = 1'b0;
            led_par[i] = 1'b1;
            led_tbl[i] = '0;
        end

        rst_n = 1'b0;
        #12;
        check("reset.busy", busy_v[1], 0);
        check("reset.done", done_v[1], 0);
        check("reset.sw_out", sw_v[1], 0);
        check("reset.ones_count", ones_v[1], 0);
        check("reset.truth_table", tt_v[1], 0);
        @(negedge clk);
        rst_n = 1'b1;

        // start together with abort in IDLE must not launch a sweep
        @(negedge clk);
        start_v[1] = 1'b1;
        abort_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        abort_v[1] = 1'b0;
        check("idle_start_abort.busy", busy_v[1], 0);
        @(posedge clk);
        #1;
        check("idle_start_abort.sw_out", sw_v[1], 0);

        run_sweep(1, 0, 0, "parity_s2");
        check("parity_s2.const_table", tt_v[1], 32'h96696996);
        check("parity_s2.const_ones", ones_v[1], 16);

        led_par[1] = 1'b0;
        led_tbl[1] = 32'hFFFF_FFFF;
        run_sweep(1, 0, 0, "tied1");
        check("tied1.const_ones", ones_v[1], 32);
        check("tied1.const_table", tt_v[1], 32'hFFFF_FFFF);
        led_tbl[1] = 32'h0000_0000;
        run_sweep(1, 0, 0, "tied0");
        check("tied0.const_ones", ones_v[1], 0);
        check("tied0.const_table", tt_v[1], 0);

        // abort during the SAMPLE of code 10 (cycle 10*3+3)
        led_par[1] = 1'b1;
        run_sweep(1, 33, 0, "abort_code10");
        check("abort_code10.high_bits", tt_v[1] >> 10, 0);

        run_sweep(1, 0, 1, "restart_ignored");
        check("restart_ignored.const_table", tt_v[1], 32'h96696996);

        run_sweep(0, 0, 0, "parity_s1");
        check("parity_s1.const_table", tt_v[0], 32'h96696996);
        run_sweep(2, 0, 0, "parity_s15");
        check("parity_s15.const_table", tt_v[2], 32'h96696996);

        // asynchronous reset between edges in the second SETTLE phase
        led_par[1] = 1'b0;
        led_tbl[1] = 32'hFFFF_FFFF;
        @(negedge clk);
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset.busy", busy_v[1], 0);
        check("async_reset.sw_out", sw_v[1], 0);
        check("async_reset.ones_count", ones_v[1], 0);
        check("async_reset.truth_table", tt_v[1], 0);
        check("async_reset.done", done_v[1], 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done_v[1] === 1'b1 || busy_v[1] === 1'b1) done_seen++;
        end
        check("async_reset.quiet_after_release", done_seen, 0);
        led_par[1] = 1'b1;
        run_sweep(1, 0, 0, "after_reset");

        for (int r = 0; r < 6; r++) begin
            idx          = $urandom_range(0, 2);
            led_par[idx] = 1'($urandom_range(0, 1));
            led_tbl[idx] = $urandom;
            ab           = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 32 * (sc_of(idx) + 1) + 1);
            run_sweep(idx, ab, 2, $sformatf("random%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
